multdiv_unit: RTL

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply, restoring divide on magnitudes.
// Fixed latency of WIDTH+1 cycles from start edge to result pulse; abort/restart cancel silently.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_abort,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_hi;
  logic [WIDTH-1:0]   r_lo, r_m;
  logic               r_qm1, r_is_mul, r_neg, r_dz;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc, r_rdy;

  logic               w_start_m, w_start_d, w_last;
  logic [WIDTH:0]     w_m_ext, w_sum, w_rsh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rsub, w_abs_a, w_abs_b, w_quo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_prod_top;
  logic               w_mul_exc, w_div_exc;

  assign w_start_m = ctrl_MULT & ~ctrl_DIV;
  assign w_start_d = ctrl_DIV & ~ctrl_MULT;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ctrl_abort)     w_next = IDLE;
    else if (w_start_m) w_next = MUL;
    else if (w_start_d) w_next = DIV;
    else begin
      case (r_state)
        MUL, DIV: if (w_last) w_next = DONE;
        DONE:     w_next = IDLE;
        default:  w_next = r_state;
      endcase
    end
  end

  // Booth accumulator carries one guard bit so a most-negative multiplicand cannot overflow it.
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  always_comb begin
    case ({r_lo[0], r_qm1})
      2'b01:   w_sum = r_hi + w_m_ext;
      2'b10:   w_sum = r_hi - w_m_ext;
      default: w_sum = r_hi;
    endcase
  end

  assign w_rsh   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_ge    = (w_rsh >= {1'b0, r_m});
  assign w_rsub  = w_rsh[WIDTH-1:0] - r_m;
  assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign w_prod     = {r_hi[WIDTH-1:0], r_lo};
  assign w_prod_top = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_mul_exc  = ~((&w_prod_top) | ~(|w_prod_top));
  // A positive quotient with its top bit set only arises from MIN / -1.
  assign w_quo      = r_neg ? -r_lo : r_lo;
  assign w_div_exc  = r_dz | (~r_neg & r_lo[WIDTH-1]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_qm1    <= 1'b0;
      r_is_mul <= 1'b0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (ctrl_abort) begin
        r_cnt <= '0;
      end else if (w_start_m) begin
        r_cnt    <= '0;
        r_hi     <= '0;
        r_lo     <= data_operandB;
        r_m      <= data_operandA;
        r_qm1    <= 1'b0;
        r_is_mul <= 1'b1;
      end else if (w_start_d) begin
        r_cnt    <= '0;
        r_hi     <= '0;
        r_lo     <= w_abs_a;
        r_m      <= w_abs_b;
        r_is_mul <= 1'b0;
        r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_dz     <= (data_operandB == '0);
      end else begin
        case (r_state)
          MUL: begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_hi  <= {w_sum[WIDTH], w_sum[WIDTH:1]};
            r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            r_qm1 <= r_lo[0];
          end
          DIV: begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_hi  <= w_ge ? {1'b0, w_rsub} : w_rsh;
            r_lo  <= {r_lo[WIDTH-2:0], w_ge};
          end
          DONE: begin
            r_rdy <= 1'b1;
            if (r_is_mul) begin
              r_result <= w_prod[WIDTH-1:0];
              r_exc    <= w_mul_exc;
            end else begin
              r_result <= r_dz ? '0 : w_quo;
              r_exc    <= w_div_exc;
            end
          end
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state != IDLE);

endmodule
